// File: rtl/fpga_ram_ctrl.sv
// Single-port byte-writable RAM controller with power-on clear and 1- or 2-cycle read latency.
// Define FPGA_RAM_CTRL_PARITY_EN to store one even-parity bit per byte lane and flag read errors.
module fpga_ram_ctrl #(
    parameter int DATAWIDTH  = 32,
    parameter int ADDRWIDTH  = 10,
    parameter int OUTREG     = 0,
    parameter int INIT_CLEAR = 1
) (
    input  logic                   PortAClk,
    input  logic                   PortAReset,
    input  logic                   PortAReqValid,
    output logic                   PortAReqReady,
    input  logic                   PortAWriteEnable,
    input  logic [DATAWIDTH/8-1:0] PortAByteEnable,
    input  logic [ADDRWIDTH-1:0]   PortAAddr,
    input  logic [DATAWIDTH-1:0]   PortADataIn,
    output logic [DATAWIDTH-1:0]   PortADataOut,
    output logic                   PortARespValid,
    output logic                   PortAInitDone,
    output logic                   PortAParityErr,
    output logic [0:0]             dbg_state_o
);
    localparam int NB       = DATAWIDTH / 8;
    localparam int MEMDEPTH = 2 ** ADDRWIDTH;

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;

    logic [0:0]           state_q, state_d;
    logic [ADDRWIDTH-1:0] clr_cnt_q, clr_cnt_d;
    logic [DATAWIDTH-1:0] mem_q [MEMDEPTH];

    logic                 accept, wr_fire, rd_fire, clr_fire;
    logic [DATAWIDTH-1:0] rd_word;
    logic                 rd_perr;
    logic                 pipe_valid;
    logic [DATAWIDTH-1:0] pipe_data;
    logic                 pipe_perr;
    logic                 out_valid_q;
    logic [DATAWIDTH-1:0] out_data_q;
    logic                 out_perr_q;

    // A request transfers on any cycle where PortAReqValid and PortAReqReady are both high;
    // ready is only offered in READY and never while reset is asserted.
    assign PortAReqReady = (state_q == ST_READY) && !PortAReset;
    assign PortAInitDone = (state_q == ST_READY) && !PortAReset;
    assign accept        = PortAReqValid && PortAReqReady;
    assign wr_fire       = accept && PortAWriteEnable;
    assign rd_fire       = accept && !PortAWriteEnable;
    assign clr_fire      = (state_q == ST_CLEAR) && !PortAReset;
    assign dbg_state_o   = state_q;

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        if (clr_fire) begin
            clr_cnt_d = clr_cnt_q + 1'b1;
            if (&clr_cnt_q) begin
                state_d = ST_READY;
            end
        end
    end

    always_ff @(posedge PortAClk) begin
        if (PortAReset) begin
            state_q   <= (INIT_CLEAR != 0) ? ST_CLEAR : ST_READY;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    // Storage is never reset; only the clear sequence zeroes it.
    always_ff @(posedge PortAClk) begin
        if (clr_fire) begin
            mem_q[clr_cnt_q] <= '0;
        end else if (wr_fire) begin
            for (int i = 0; i < NB; i++) begin
                if (PortAByteEnable[i]) begin
                    mem_q[PortAAddr][8*i +: 8] <= PortADataIn[8*i +: 8];
                end
            end
        end
    end

    assign rd_word = mem_q[PortAAddr];

`ifdef FPGA_RAM_CTRL_PARITY_EN
    logic [NB-1:0] par_q [MEMDEPTH];

    always_ff @(posedge PortAClk) begin
        if (clr_fire) begin
            par_q[clr_cnt_q] <= '0;
        end else if (wr_fire) begin
            for (int i = 0; i < NB; i++) begin
                if (PortAByteEnable[i]) begin
                    par_q[PortAAddr][i] <= ^PortADataIn[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        rd_perr = 1'b0;
        for (int i = 0; i < NB; i++) begin
            if ((^rd_word[8*i +: 8]) != par_q[PortAAddr][i]) begin
                rd_perr = 1'b1;
            end
        end
    end
`else
    assign rd_perr = 1'b0;
`endif

    // Optional extra stage: the array read lands here first, then in the output register.
    generate
        if (OUTREG != 0) begin : g_outreg
            logic                 s1_valid_q;
            logic [DATAWIDTH-1:0] s1_data_q;
            logic                 s1_perr_q;

            always_ff @(posedge PortAClk) begin
                if (PortAReset) begin
                    s1_valid_q <= 1'b0;
                end else begin
                    s1_valid_q <= rd_fire;
                end
            end

            always_ff @(posedge PortAClk) begin
                if (rd_fire) begin
                    s1_data_q <= rd_word;
                    s1_perr_q <= rd_perr;
                end
            end

            assign pipe_valid = s1_valid_q;
            assign pipe_data  = s1_data_q;
            assign pipe_perr  = s1_perr_q;
        end else begin : g_direct
            assign pipe_valid = rd_fire;
            assign pipe_data  = rd_word;
            assign pipe_perr  = rd_perr;
        end
    endgenerate

    always_ff @(posedge PortAClk) begin
        if (PortAReset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_perr_q  <= 1'b0;
        end else begin
            out_valid_q <= pipe_valid;
            out_perr_q  <= pipe_valid && pipe_perr;
            if (pipe_valid) begin
                out_data_q <= pipe_data;
            end
        end
    end

    assign PortADataOut   = out_data_q;
    assign PortARespValid = out_valid_q;
    assign PortAParityErr = out_perr_q;

endmodule

// File: tb/tb_fpga_ram_ctrl.sv
// Bench for fpga_ram_ctrl: one 1-cycle and one 2-cycle instance driven in lockstep, checked
// against an array/queue memory model, directed vectors, clear/reset sequences and random traffic.
module tb_fpga_ram_ctrl;
    localparam int DW    = 32;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    typedef struct {
        int          due;
        logic [31:0] data;
        logic        perr;
    } resp_t;

    typedef struct {
        logic        we;
        logic [3:0]  be;
        logic [3:0]  addr;
        logic [31:0] din;
        logic [31:0] exp;
    } vec_t;

    // ---------------- clock / reset / DUT ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          req_valid;
    logic          we;
    logic [3:0]    be;
    logic [AW-1:0] addr;
    logic [DW-1:0] din;

    logic          rdy0, rv0, done0, perr0;
    logic [DW-1:0] dout0;
    logic [0:0]    dbg0;
    logic          rdy1, rv1, done1, perr1;
    logic [DW-1:0] dout1;
    logic [0:0]    dbg1;

    fpga_ram_ctrl #(.DATAWIDTH(DW), .ADDRWIDTH(AW), .OUTREG(0), .INIT_CLEAR(1)) dut0 (
        .PortAClk(clk), .PortAReset(rst), .PortAReqValid(req_valid), .PortAReqReady(rdy0),
        .PortAWriteEnable(we), .PortAByteEnable(be), .PortAAddr(addr), .PortADataIn(din),
        .PortADataOut(dout0), .PortARespValid(rv0), .PortAInitDone(done0),
        .PortAParityErr(perr0), .dbg_state_o(dbg0)
    );

    fpga_ram_ctrl #(.DATAWIDTH(DW), .ADDRWIDTH(AW), .OUTREG(1), .INIT_CLEAR(1)) dut1 (
        .PortAClk(clk), .PortAReset(rst), .PortAReqValid(req_valid), .PortAReqReady(rdy1),
        .PortAWriteEnable(we), .PortAByteEnable(be), .PortAAddr(addr), .PortADataIn(din),
        .PortADataOut(dout1), .PortARespValid(rv1), .PortAInitDone(done1),
        .PortAParityErr(perr1), .dbg_state_o(dbg1)
    );

    // ---------------- reference model / scoreboard ----------------
    logic [31:0] mdl_mem [DEPTH];
    logic [3:0]  mdl_bad [DEPTH];
    resp_t       exp_q0[$];
    resp_t       exp_q1[$];
    logic [31:0] last_d [2];
    int          cyc       = 0;
    int          clr_left  = 0;
    bit          started   = 1'b0;
    int          n_tests   = 0;
    int          n_fail    = 0;

    function automatic bit mdl_ready();
        return started && (rst === 1'b0) && (clr_left == 0);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic check_dut(input int k, input logic rdy, input logic done, input logic rv,
                             input logic perr, input logic [31:0] dout, input logic [0:0] dbg);
        resp_t f;
        bit    have;
        string tag;
        have = 1'b0;
        f    = '{due: 0, data: 32'h0, perr: 1'b0};
        tag  = (k == 0) ? "lat1" : "lat2";
        if (k == 0 && exp_q0.size() > 0 && exp_q0[0].due == cyc) begin
            f = exp_q0.pop_front();
            have = 1'b1;
        end
        if (k == 1 && exp_q1.size() > 0 && exp_q1[0].due == cyc) begin
            f = exp_q1.pop_front();
            have = 1'b1;
        end
        if (have) last_d[k] = f.data;
        chk({tag, ".resp_valid"}, 32'(rv), 32'(have));
        chk({tag, ".data_out"}, dout, last_d[k]);
        chk({tag, ".parity_err"}, 32'(perr), 32'(have && f.perr));
        chk({tag, ".req_ready"}, 32'(rdy), 32'(mdl_ready()));
        chk({tag, ".init_done"}, 32'(done), 32'(mdl_ready()));
        chk({tag, ".state"}, 32'(dbg), 32'(mdl_ready()));
    endtask

    // Applies the current inputs across one rising edge, updates the model, then checks.
    task automatic tick(input bit use_exp, input logic [31:0] exp_val);
        bit    acc;
        resp_t r;
        acc = mdl_ready() && (req_valid === 1'b1);
        if (acc && we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mdl_mem[addr][8*i +: 8] = din[8*i +: 8];
                    mdl_bad[addr][i] = 1'b0;
                end
            end
        end else if (acc) begin
            r.data = use_exp ? exp_val : mdl_mem[addr];
            r.perr = |mdl_bad[addr];
            r.due  = cyc + 1;
            exp_q0.push_back(r);
            r.due  = cyc + 2;
            exp_q1.push_back(r);
        end
        @(posedge clk);
        cyc++;
        if (rst) begin
            started  = 1'b1;
            clr_left = DEPTH;
            exp_q0.delete();
            exp_q1.delete();
            last_d[0] = '0;
            last_d[1] = '0;
        end else if (clr_left > 0) begin
            clr_left--;
            if (clr_left == 0) begin
                for (int i = 0; i < DEPTH; i++) begin
                    mdl_mem[i] = '0;
                    mdl_bad[i] = '0;
                end
            end
        end
        #1;
        if (started) begin
            check_dut(0, rdy0, done0, rv0, perr0, dout0, dbg0);
            check_dut(1, rdy1, done1, rv1, perr1, dout1, dbg1);
        end
    endtask

    task automatic drive_random();
        req_valid = 1'($urandom_range(0, 1));
        we        = 1'($urandom_range(0, 1));
        be        = 4'($urandom_range(0, 15));
        addr      = 4'($urandom_range(0, DEPTH - 1));
        din       = $urandom;
    endtask

    // ---------------- test sequence ----------------
    vec_t tbl [14];
    int   n;

    initial begin
        tbl[0]  = '{we: 1'b0, be: 4'h0, addr: 4'd5, din: 32'h0,        exp: 32'h00000000};
        tbl[1]  = '{we: 1'b1, be: 4'hF, addr: 4'd3, din: 32'hDEADBEEF, exp: 32'h0};
        tbl[2]  = '{we: 1'b1, be: 4'h5, addr: 4'd3, din: 32'h11223344, exp: 32'h0};
        tbl[3]  = '{we: 1'b0, be: 4'h0, addr: 4'd3, din: 32'h0,        exp: 32'hDE22BE44};
        tbl[4]  = '{we: 1'b1, be: 4'hF, addr: 4'd9, din: 32'h12345678, exp: 32'h0};
        tbl[5]  = '{we: 1'b0, be: 4'h0, addr: 4'd9, din: 32'h0,        exp: 32'h12345678};
        tbl[6]  = '{we: 1'b1, be: 4'hF, addr: 4'd1, din: 32'h0000000A, exp: 32'h0};
        tbl[7]  = '{we: 1'b1, be: 4'hF, addr: 4'd2, din: 32'h0000000B, exp: 32'h0};
        tbl[8]  = '{we: 1'b1, be: 4'hF, addr: 4'd3, din: 32'h0000000C, exp: 32'h0};
        tbl[9]  = '{we: 1'b0, be: 4'h0, addr: 4'd1, din: 32'h0,        exp: 32'h0000000A};
        tbl[10] = '{we: 1'b0, be: 4'h0, addr: 4'd2, din: 32'h0,        exp: 32'h0000000B};
        tbl[11] = '{we: 1'b0, be: 4'h0, addr: 4'd3, din: 32'h0,        exp: 32'h0000000C};
        tbl[12] = '{we: 1'b1, be: 4'h0, addr: 4'd9, din: 32'hFFFFFFFF, exp: 32'h0};
        tbl[13] = '{we: 1'b0, be: 4'h0, addr: 4'd9, din: 32'h0,        exp: 32'h12345678};

        for (int i = 0; i < DEPTH; i++) begin
            mdl_mem[i] = 'x;
            mdl_bad[i] = '0;
        end
        rst = 1'b1; req_valid = 1'b0; we = 1'b0; be = '0; addr = '0; din = '0;

        // Power-on reset, then ready must stay low for exactly DEPTH cycles.
        tick(0, 0);
        tick(0, 0);
        rst = 1'b0;
        n = 0;
        while (rdy0 !== 1'b1 && n < 40) begin
            tick(0, 0);
            n++;
        end
        chk("clear_length", 32'(n), 32'(DEPTH));

        // Reset pulse at clear cycle 7 restarts the clear; requests during clear are ignored.
        rst = 1'b1;
        tick(0, 0);
        rst = 1'b0;
        for (int i = 0; i < 7; i++) begin
            drive_random();
            req_valid = 1'b1;
            tick(0, 0);
        end
        rst = 1'b1;
        req_valid = 1'b0;
        tick(0, 0);
        rst = 1'b0;
        n = 0;
        while (done0 !== 1'b1 && n < 40) begin
            drive_random();
            tick(0, 0);
            n++;
        end
        chk("restart_clear_length", 32'(n), 32'(DEPTH));
        req_valid = 1'b0;
        tick(0, 0);

        // Directed vectors, back-to-back.
        foreach (tbl[i]) begin
            req_valid = 1'b1;
            we        = tbl[i].we;
            be        = tbl[i].be;
            addr      = tbl[i].addr;
            din       = tbl[i].din;
            tick(!tbl[i].we, tbl[i].exp);
        end
        req_valid = 1'b0;
        repeat (4) tick(0, 0);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            drive_random();
            tick(0, 0);
        end
        req_valid = 1'b0;
        repeat (4) tick(0, 0);

        // Parity corruption: flip one stored data bit of address 2, then read it back.
`ifdef FPGA_RAM_CTRL_PARITY_EN
        dut0.mem_q[2][0] = ~dut0.mem_q[2][0];
        dut1.mem_q[2][0] = ~dut1.mem_q[2][0];
        mdl_mem[2][0] = ~mdl_mem[2][0];
        mdl_bad[2][0] = 1'b1;
`endif
        req_valid = 1'b1;
        we        = 1'b0;
        addr      = 4'd2;
        tick(0, 0);
        req_valid = 1'b0;
        repeat (4) tick(0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fpga_ram_ctrl.md
FPGA_RAM_CTRL -- requirements
Module: fpga_ram_ctrl

Interface
REQ-001 SHALL have parameter DATAWIDTH, default 32, word width in bits, legal values are multiples of 8.
REQ-002 SHALL have parameter ADDRWIDTH, default 10, address width; MEMDEPTH = 2**ADDRWIDTH words.
REQ-003 SHALL have parameter OUTREG, default 0, read latency select: 0 gives 1 cycle, 1 gives 2 cycles.
REQ-004 SHALL have parameter INIT_CLEAR, default 1: 1 zeroes the memory after reset, 0 skips the clear.
REQ-005 SHALL use one clock and a synchronous, active-high reset.
REQ-006 PortAClk  in  1  the only clock; all logic is on its rising edge.
REQ-007 PortAReset  in  1  synchronous, active-high reset.
REQ-008 PortAReqValid  in  1  request strobe.
REQ-009 PortAReqReady  out  1  request accept qualifier.
REQ-010 PortAWriteEnable  in  1  1 = write request, 0 = read request.
REQ-011 PortAByteEnable  in  DATAWIDTH/8  per-byte write lane enable; bit i covers bits [8i+7:8i].
REQ-012 PortAAddr  in  ADDRWIDTH  word address.
REQ-013 PortADataIn  in  DATAWIDTH  write data.
REQ-014 PortADataOut  out  DATAWIDTH  read data, registered.
REQ-015 PortARespValid  out  1  one-cycle pulse marking valid PortADataOut.
REQ-016 PortAInitDone  out  1  high once the clear has finished (or right after reset if INIT_CLEAR=0).
REQ-017 PortAParityErr  out  1  read parity error flag; the port is always present.

Function
REQ-018 SHALL accept a request in any cycle where PortAReqValid and PortAReqReady are both 1; one request per cycle, back-to-back allowed.
REQ-019 SHALL have two states: CLEAR and READY. PortAReqReady = 1 only in READY.
REQ-020 CLEAR: writes zero to address counter 0..MEMDEPTH-1, one word per cycle, for exactly MEMDEPTH cycles; after the last address it moves to READY and sets PortAInitDone.
REQ-021 Requests presented during CLEAR SHALL not be accepted and SHALL not change memory or outputs.
REQ-022 Accepted write: only lanes with a set PortAByteEnable bit are updated; other lanes keep their value; no response is generated.
REQ-023 Accepted write with PortAByteEnable all zero SHALL change nothing.
REQ-024 Accepted read SHALL put mem[PortAAddr] on PortADataOut with PortARespValid=1 exactly 1 cycle (OUTREG=0) or 2 cycles (OUTREG=1) after acceptance.
REQ-025 PortADataOut SHALL hold its last read value between responses and during writes.
REQ-026 A read accepted the cycle after a write to the same address SHALL return the newly written data.
REQ-027 With OUTREG=1, reads accepted in consecutive cycles SHALL produce responses in consecutive cycles, in order.

Reset
REQ-028 While PortAReset=1, SHALL drive PortADataOut=0, PortARespValid=0, PortAReqReady=0, PortAInitDone=0, PortAParityErr=0, and flush any pending read-pipeline responses.
REQ-029 After PortAReset falls, SHALL enter CLEAR with the counter at 0 if INIT_CLEAR=1, otherwise READY.
REQ-030 Reset asserted mid-clear SHALL restart the clear from address 0.
REQ-031 Memory contents SHALL not be reset except by the CLEAR sequence.

Configuration
REQ-032 Macro FPGA_RAM_CTRL_PARITY_EN defined: one even-parity bit is stored per byte lane and written with that lane.
REQ-033 With the macro: CLEAR writes parity 0, and PortAParityErr is asserted with PortARespValid when any lane's stored parity mismatches its data; it is 0 otherwise.
REQ-034 Without the macro: no parity storage exists and PortAParityErr is tied to 0.

Verification (DATAWIDTH=32, ADDRWIDTH=4)
REQ-035 Release reset, INIT_CLEAR=1 -> PortAReqReady=0 for 16 cycles, then PortAReqReady=1 and PortAInitDone=1; a read of addr 5 returns 0x00000000.
REQ-036 Write 0xDEADBEEF to addr 3 with BE=0xF, then write 0x11223344 with BE=0x5, then read addr 3 -> 0xDE22BE44.
REQ-037 OUTREG=1: reads of addr 1, 2, 3 in consecutive cycles (contents 0xA, 0xB, 0xC) -> RespValid high for 3 consecutive cycles starting 2 cycles after the first accept, data 0xA, 0xB, 0xC.
REQ-038 Assert reset at clear cycle 7 for 1 cycle -> the clear restarts and PortAInitDone rises 16 cycles after reset falls.
REQ-039 Write 0x12345678 to addr 9, read addr 9 in the next cycle -> 0x12345678 with RespValid exactly 1 cycle later (OUTREG=0).
REQ-040 With FPGA_RAM_CTRL_PARITY_EN: force-flip a data bit of addr 2 in memory, then read addr 2 -> PortAParityErr=1 coincident with PortARespValid.
